// File: rtl/mem_pkg.sv
// Shared load/store definitions: access-size codes, responder FSM states and
// the byte-lane helpers that the core's load/store unit uses as well.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } memState_t;

    // Pull the addressed lane(s) down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] laneExtract(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size,
                                                input logic        signExt);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: result = {{24{signExt & shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = {{16{signExt & shifted[15]}}, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] laneMerge(input logic [31:0] oldWord,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {offset, 3'b000};
        data = wdata << {offset, 3'b000};
        return (oldWord & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between the core (master) and the data
// memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_ram_sp.sv
// Single-port 32-bit synchronous RAM with registered read, written so that
// FPGA tools map it onto block RAM.
module mem_ram_sp #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time over valid/ready, WAIT_CYCLES
// wait states, then a byte/half/word access and a one-cycle response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clock,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    memState_t   state;
    memState_t   nextState;
    logic [3:0]  waitCount;
    logic        transfer;
    logic        capWe;
    logic        capSigned;
    logic [1:0]  capSize;
    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic        capErr;
    logic        ramWe;
    logic [31:0] ramRdata;
    logic [31:0] ramWdata;
    logic [31:0] respRdata;
    logic        respErr;

    assign transfer = bus.req_valid && (state == IDLE);

    always_comb begin
        capErr = 1'b0;
        if (capSize == 2'b11) capErr = 1'b1;
        if (capSize == SZ_HALF && capAddr[0]) capErr = 1'b1;
        if (capSize == SZ_WORD && capAddr[1:0] != 2'b00) capErr = 1'b1;
        if ((capAddr >> (ADDR_W + 2)) != 32'd0) capErr = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The first WAIT cycle decodes the captured request: errors leave from
    // there, legal requests spend WAIT_CYCLES more cycles before ACCESS.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (transfer) nextState = WAIT;
            WAIT:    if (capErr) nextState = RESP;
                     else if (waitCount == 4'd0) nextState = ACCESS;
            ACCESS:  nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = respRdata;
        bus.resp_err   = respErr;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            waitCount <= 4'd0;
            capWe     <= 1'b0;
            capSigned <= 1'b0;
            capSize   <= 2'b00;
            capAddr   <= 32'd0;
            capWdata  <= 32'd0;
        end else if (transfer) begin
            waitCount <= WAIT_INIT;
            capWe     <= bus.req_we;
            capSigned <= bus.req_signed;
            capSize   <= bus.req_size;
            capAddr   <= bus.req_addr;
            capWdata  <= bus.req_wdata;
        end else if (state == WAIT && waitCount != 4'd0) begin
            waitCount <= waitCount - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            respRdata <= 32'd0;
            respErr   <= 1'b0;
        end else if (state == WAIT && capErr) begin
            respRdata <= 32'd0;
            respErr   <= 1'b1;
        end else if (state == ACCESS) begin
            respRdata <= capWe ? 32'd0 : laneExtract(ramRdata, capAddr[1:0], capSize, capSigned);
            respErr   <= 1'b0;
        end
    end

    // The RAM address is held from capture, so its registered output already
    // holds the target word when ACCESS begins; stores write the merged word back.
    assign ramWe    = (state == ACCESS) && capWe;
    assign ramWdata = laneMerge(ramRdata, capWdata, capAddr[1:0], capSize);

    mem_ram_sp #(
        .ADDR_W(ADDR_W)
    ) ram (
        .clock(clock),
        .we   (ramWe),
        .addr (capAddr[ADDR_W+1:2]),
        .wdata(ramWdata),
        .rdata(ramRdata)
    );

endmodule
